// File: rtl/long_op_scoreboard_if.sv
// ---------------------------------------------------------------------------
// long_op_scoreboard_if
//
// Bundles the decode-stage issue request, the hazard verdict, the divider
// sequencing controls and the divider write-back strobe that pass between the
// decoder/issue logic and long_op_scoreboard.
//
// Signals (REG_ADDR_WIDTH = register index width):
//   issue_valid, issue_long, rwe       decoder -> scoreboard, request qualifiers
//   rd, rs1, rs2                       decoder -> scoreboard, register indices
//   uses_rs1, uses_rs2                 decoder -> scoreboard, operand read flags
//   f_rd, f_d1, f_d2                   decoder -> scoreboard, 1 = FP file
//   issue_ready, stall                 scoreboard -> decoder, issue verdict
//   div_start, div_step                scoreboard -> divider controls
//   wb_valid, wb_rd, wb_f              scoreboard -> register-file write port
//   busy                               scoreboard -> anyone, sequencer active
//
// Modports: master = decoder / issue side, slave = the scoreboard itself.
// ---------------------------------------------------------------------------
interface long_op_scoreboard_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      issue_valid;
    logic                      issue_long;
    logic                      rwe;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      uses_rs1;
    logic                      uses_rs2;
    logic                      f_rd;
    logic                      f_d1;
    logic                      f_d2;

    logic                      issue_ready;
    logic                      stall;
    logic                      div_start;
    logic                      div_step;
    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      wb_f;
    logic                      busy;

    modport master (
        output issue_valid, issue_long, rwe, rd, rs1, rs2,
               uses_rs1, uses_rs2, f_rd, f_d1, f_d2,
        input  issue_ready, stall, div_start, div_step,
               wb_valid, wb_rd, wb_f, busy
    );

    modport slave (
        input  issue_valid, issue_long, rwe, rd, rs1, rs2,
               uses_rs1, uses_rs2, f_rd, f_d1, f_d2,
        output issue_ready, stall, div_start, div_step,
               wb_valid, wb_rd, wb_f, busy
    );
endinterface

// File: rtl/long_op_scoreboard.sv
// ---------------------------------------------------------------------------
// long_op_scoreboard
//
// Issue-stage hazard controller and sequencer for the shared iterative divide
// unit. Tracks the destination of the single in-flight long op in separate
// integer and FP pending vectors, stalls issue on RAW / WAW / structural /
// write-port hazards, and sequences the divider (start, step, write-back).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   sb     long_op_scoreboard_if.slave (issue request in; verdict, divider
//          controls and write-back out)
//
// issue_ready, stall and div_start are combinational from inputs and state.
// div_step, wb_valid, wb_rd, wb_f and busy come straight from flops that are
// loaded with the decode of the next FSM state.
// The interface REG_ADDR_WIDTH must match this module's REG_ADDR_WIDTH.
// ---------------------------------------------------------------------------
module long_op_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int DIV_LATENCY    = 32,
    parameter int CNT_WIDTH      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    long_op_scoreboard_if.slave   sb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_REGS-1:0]       int_pend_q, int_pend_d;
    logic [NUM_REGS-1:0]       fp_pend_q, fp_pend_d;
    logic [REG_ADDR_WIDTH-1:0] lat_rd_q, lat_rd_d;
    logic                      lat_f_q, lat_f_d;
    logic                      lat_we_q, lat_we_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    // Registered outputs
    logic                      div_step_q, div_step_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                      wb_f_q, wb_f_d;
    logic                      busy_q, busy_d;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic pend_rs1, pend_rs2, pend_rd;
    logic raw1_haz, raw2_haz, waw_haz, struct_haz, port_haz;
    logic issue_ready;
    logic fire_long;
    logic new_we;

    always_comb begin
        pend_rs1   = sb.f_d1 ? fp_pend_q[sb.rs1] : int_pend_q[sb.rs1];
        pend_rs2   = sb.f_d2 ? fp_pend_q[sb.rs2] : int_pend_q[sb.rs2];
        pend_rd    = sb.f_rd ? fp_pend_q[sb.rd]  : int_pend_q[sb.rd];

        raw1_haz   = sb.uses_rs1 & pend_rs1;
        raw2_haz   = sb.uses_rs2 & pend_rs2;
        waw_haz    = sb.rwe & pend_rd;
        struct_haz = sb.issue_long & (state_q != IDLE);
        // One register-file write port: the divider result owns it in WB.
        port_haz   = sb.rwe & (state_q == WB);

        // Nothing issues while reset is asserted.
        issue_ready = rst_n & ~(raw1_haz | raw2_haz | waw_haz | struct_haz | port_haz);
        fire_long   = sb.issue_valid & issue_ready & sb.issue_long;

        // Writes to integer x0 are discarded, so they are never tracked.
        new_we      = sb.rwe & ~(~sb.f_rd & (sb.rd == '0));
    end

    assign sb.issue_ready = issue_ready;
    // Gated by rst_n so stall reads 0 (not 1) while held in reset.
    assign sb.stall       = rst_n & sb.issue_valid & ~issue_ready;
    assign sb.div_start   = fire_long;

    // -----------------------------------------------------------------------
    // Pending-bit next state, one slice per register in each file.
    // A bit is set when a long op writing it fires and cleared on the edge
    // that ends its WB cycle. Both never happen in the same cycle because a
    // long op can only fire from IDLE.
    // -----------------------------------------------------------------------
    logic [NUM_REGS-1:0] set_int, clr_int, set_fp, clr_fp;
    logic                in_wb;

    assign in_wb = (state_q == WB);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            assign set_int[gi]    = fire_long & new_we & ~sb.f_rd &
                                    (sb.rd == REG_ADDR_WIDTH'(gi));
            assign set_fp[gi]     = fire_long & new_we &  sb.f_rd &
                                    (sb.rd == REG_ADDR_WIDTH'(gi));
            assign clr_int[gi]    = in_wb & lat_we_q & ~lat_f_q &
                                    (lat_rd_q == REG_ADDR_WIDTH'(gi));
            assign clr_fp[gi]     = in_wb & lat_we_q &  lat_f_q &
                                    (lat_rd_q == REG_ADDR_WIDTH'(gi));
            assign int_pend_d[gi] = (int_pend_q[gi] | set_int[gi]) & ~clr_int[gi];
            assign fp_pend_d[gi]  = (fp_pend_q[gi]  | set_fp[gi])  & ~clr_fp[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Sequencer next state and next registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        lat_rd_d = lat_rd_q;
        lat_f_d  = lat_f_q;
        lat_we_d = lat_we_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (fire_long) begin
                    lat_rd_d = sb.rd;
                    lat_f_d  = sb.f_rd;
                    lat_we_d = new_we;
                    // RUN lasts DIV_LATENCY cycles: counts DIV_LATENCY-1 .. 0.
                    cnt_d    = CNT_WIDTH'(DIV_LATENCY - 1);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered so that the flops
        // present them in the same cycle the state register does.
        div_step_d = (state_d == RUN);
        wb_valid_d = (state_d == WB) & lat_we_d;
        wb_rd_d    = (state_d == WB) ? lat_rd_d : '0;
        wb_f_d     = (state_d == WB) & lat_f_d;
        busy_d     = (state_d != IDLE);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            int_pend_q <= '0;
            fp_pend_q  <= '0;
            lat_rd_q   <= '0;
            lat_f_q    <= 1'b0;
            lat_we_q   <= 1'b0;
            cnt_q      <= '0;
            div_step_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_f_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
            fp_pend_q  <= fp_pend_d;
            lat_rd_q   <= lat_rd_d;
            lat_f_q    <= lat_f_d;
            lat_we_q   <= lat_we_d;
            cnt_q      <= cnt_d;
            div_step_q <= div_step_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_f_q     <= wb_f_d;
            busy_q     <= busy_d;
        end
    end

    assign sb.div_step = div_step_q;
    assign sb.wb_valid = wb_valid_q;
    assign sb.wb_rd    = wb_rd_q;
    assign sb.wb_f     = wb_f_q;
    assign sb.busy     = busy_q;

endmodule

// File: tb/tb_long_op_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_long_op_scoreboard
//
// Directed bench for long_op_scoreboard with DIV_LATENCY = 32. Inputs change
// at the falling clock edge; combinational outputs are checked 1 ns after the
// inputs settle and registered outputs are read in the low phase, well away
// from the rising edge.
// ---------------------------------------------------------------------------
module tb_long_op_scoreboard;

    localparam int RAW_W = 5;
    localparam int LAT   = 32;

    logic clk;
    logic rst_n;

    int n_assert = 0;
    int n_fail   = 0;

    long_op_scoreboard_if #(.REG_ADDR_WIDTH(RAW_W)) bus ();

    long_op_scoreboard #(
        .REG_ADDR_WIDTH(RAW_W),
        .NUM_REGS      (32),
        .DIV_LATENCY   (LAT),
        .CNT_WIDTH     (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one decode-stage request and let combinational outputs settle.
    task automatic op(input logic v, input logic lng, input logic we,
                      input int rd_i, input int rs1_i, input int rs2_i,
                      input logic u1, input logic u2,
                      input logic frd, input logic fd1, input logic fd2);
        bus.issue_valid = v;
        bus.issue_long  = lng;
        bus.rwe         = we;
        bus.rd          = rd_i[RAW_W-1:0];
        bus.rs1         = rs1_i[RAW_W-1:0];
        bus.rs2         = rs2_i[RAW_W-1:0];
        bus.uses_rs1    = u1;
        bus.uses_rs2    = u2;
        bus.f_rd        = frd;
        bus.f_d1        = fd1;
        bus.f_d2        = fd2;
        #1;
        if (v)
            $display("t=%0t present long=%0b rwe=%0b rd=%0s%0d rs1=%0s%0d rs2=%0s%0d ready=%0b",
                     $time, lng, we, frd ? "f" : "x", rd_i, fd1 ? "f" : "x", rs1_i,
                     fd2 ? "f" : "x", rs2_i, bus.issue_ready);
    endtask

    task automatic clr_in();
        op(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (bus.busy !== 1'b0 && g < 60) begin
            next_cyc();
            g++;
        end
        chk(tag, bus.busy, 1'b0);
    endtask

    initial begin
        int steps;
        int wbs;
        int guard;

        // ---------------- Reset held with ADD x1,x2,x3 presented ----------
        rst_n = 1'b0;
        op(1, 0, 1, 1, 2, 3, 1, 1, 0, 0, 0);
        next_cyc();
        next_cyc();
        chk("rst_issue_ready", bus.issue_ready, 1'b0);
        chk("rst_stall",       bus.stall,       1'b0);
        chk("rst_div_start",   bus.div_start,   1'b0);
        chk("rst_div_step",    bus.div_step,    1'b0);
        chk("rst_wb_valid",    bus.wb_valid,    1'b0);
        chk("rst_wb_rd",       bus.wb_rd,       5'd0);
        chk("rst_wb_f",        bus.wb_f,        1'b0);
        chk("rst_busy",        bus.busy,        1'b0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", bus.issue_ready, 1'b1);
        next_cyc();

        // ---------------- DIV x5 then dependent ADD x6,x5,x1 --------------
        op(1, 1, 1, 5, 1, 2, 1, 1, 0, 0, 0);
        chk("div_start_T", bus.div_start, 1'b1);
        chk("div_busy_T",  bus.busy,      1'b0);
        next_cyc();
        op(1, 0, 1, 6, 5, 1, 1, 1, 0, 0, 0);
        for (int k = 1; k <= LAT; k++) begin
            chk("raw_stall_run",  bus.stall,     1'b1);
            chk("div_step_run",   bus.div_step,  1'b1);
            chk("no_wb_run",      bus.wb_valid,  1'b0);
            chk("no_start_run",   bus.div_start, 1'b0);
            next_cyc();
        end
        chk("wb_valid_T33", bus.wb_valid, 1'b1);
        chk("wb_rd_T33",    bus.wb_rd,    5'd5);
        chk("wb_f_T33",     bus.wb_f,     1'b0);
        chk("step_off_T33", bus.div_step, 1'b0);
        chk("raw_stall_wb", bus.stall,    1'b1);
        next_cyc();
        chk("raw_issue_T34",  bus.issue_ready, 1'b1);
        chk("raw_nostall_T34", bus.stall,      1'b0);
        chk("idle_T34",       bus.busy,        1'b0);
        chk("wb_off_T34",     bus.wb_valid,    1'b0);
        next_cyc();

        // ---------------- Register-file separation ------------------------
        op(1, 1, 1, 5, 1, 2, 1, 1, 0, 0, 0);
        chk("sep_div_start", bus.div_start, 1'b1);
        next_cyc();
        op(1, 0, 1, 6, 5, 1, 1, 1, 1, 1, 1);      // FADD.S f6,f5,f1
        chk("sep_fadd_ready", bus.issue_ready, 1'b1);
        next_cyc();
        op(1, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0);      // writes f5
        chk("sep_f5_write_ready", bus.issue_ready, 1'b1);
        next_cyc();
        op(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);      // writes x5
        chk("sep_waw_stall", bus.stall, 1'b1);
        op(1, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0);      // reads x5 on rs2
        chk("sep_raw2_stall", bus.stall, 1'b1);
        clr_in();
        wait_idle("sep_drain");
        next_cyc();

        // ---------------- FP divide to f3 ---------------------------------
        op(1, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0);
        chk("fdiv_start", bus.div_start, 1'b1);
        next_cyc();
        op(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1);      // reads f3
        chk("fdiv_raw_f3", bus.stall, 1'b1);
        op(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0);      // reads x3
        chk("fdiv_x3_ready", bus.issue_ready, 1'b1);
        op(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1);      // f3 index but operand unused
        chk("fdiv_unused_ready", bus.issue_ready, 1'b1);
        clr_in();
        guard = 0;
        while (bus.wb_valid !== 1'b1 && guard < 40) begin
            next_cyc();
            guard++;
        end
        chk("fdiv_wb_seen",    bus.wb_valid, 1'b1);
        chk("fdiv_wb_latency", guard,        32'd32);
        chk("fdiv_wb_f",       bus.wb_f,     1'b1);
        chk("fdiv_wb_rd",      bus.wb_rd,    5'd3);
        wait_idle("fdiv_drain");

        // ---------------- Back-to-back DIV, then port hazard --------------
        op(1, 1, 1, 10, 1, 2, 1, 1, 0, 0, 0);
        chk("b2b_first_start", bus.div_start, 1'b1);
        next_cyc();
        op(1, 1, 1, 11, 12, 13, 1, 1, 0, 0, 0);
        for (int k = 1; k <= LAT + 1; k++) begin
            chk("b2b_struct_stall", bus.stall,     1'b1);
            chk("b2b_no_start",     bus.div_start, 1'b0);
            next_cyc();
        end
        chk("b2b_second_start", bus.div_start, 1'b1);
        chk("b2b_second_ready", bus.stall,     1'b0);
        next_cyc();
        clr_in();
        repeat (LAT) next_cyc();
        chk("port_wb_valid", bus.wb_valid, 1'b1);
        chk("port_wb_rd",    bus.wb_rd,    5'd11);
        op(1, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0);      // store, no rd write
        chk("port_store_ready", bus.issue_ready, 1'b1);
        op(1, 0, 1, 9, 1, 2, 1, 1, 0, 0, 0);      // ADD x9,x1,x2
        chk("port_add_stall", bus.stall, 1'b1);
        next_cyc();
        chk("port_add_ready",   bus.issue_ready, 1'b1);
        chk("port_add_nostall", bus.stall,       1'b0);
        chk("port_idle",        bus.busy,        1'b0);
        next_cyc();

        // ---------------- DIV x0: full sequence, no write-back ------------
        op(1, 1, 1, 0, 1, 2, 1, 1, 0, 0, 0);
        chk("x0_div_start", bus.div_start, 1'b1);
        next_cyc();
        op(1, 0, 1, 7, 0, 0, 1, 1, 0, 0, 0);      // ADD x7,x0,x0
        steps = 0;
        wbs   = 0;
        for (int k = 1; k <= LAT; k++) begin
            chk("x0_add_nostall", bus.stall, 1'b0);
            steps += int'(bus.div_step);
            wbs   += int'(bus.wb_valid);
            next_cyc();
        end
        chk("x0_wb_cycle_busy", bus.busy,     1'b1);
        chk("x0_wb_cycle_wbv",  bus.wb_valid, 1'b0);
        chk("x0_wb_cycle_step", bus.div_step, 1'b0);
        clr_in();
        for (int k = 0; k < 4; k++) begin
            wbs += int'(bus.wb_valid);
            next_cyc();
        end
        chk("x0_step_count", steps, 32'd32);
        chk("x0_wb_count",   wbs,   32'd0);
        chk("x0_idle",       bus.busy, 1'b0);

        // ---------------- FDIV f0: f0 is an ordinary register -------------
        op(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("f0_div_start", bus.div_start, 1'b1);
        next_cyc();
        op(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);      // reads f0
        chk("f0_raw_stall", bus.stall, 1'b1);
        op(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);      // reads x0
        chk("f0_x0_ready", bus.issue_ready, 1'b1);
        clr_in();
        wait_idle("f0_drain");
        next_cyc();

        // ---------------- Reset mid-operation -----------------------------
        op(1, 1, 1, 5, 1, 2, 1, 1, 0, 0, 0);
        chk("mid_div_start", bus.div_start, 1'b1);
        next_cyc();
        clr_in();
        repeat (9) next_cyc();
        chk("mid_busy_T10", bus.busy, 1'b1);
        rst_n = 1'b0;
        op(1, 0, 1, 6, 5, 1, 1, 1, 0, 0, 0);
        chk("mid_rst_ready", bus.issue_ready, 1'b0);
        chk("mid_rst_stall", bus.stall,       1'b0);
        next_cyc();
        chk("mid_rst_busy", bus.busy,     1'b0);
        chk("mid_rst_step", bus.div_step, 1'b0);
        chk("mid_rst_wbv",  bus.wb_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("mid_add_ready", bus.issue_ready, 1'b1);
        next_cyc();
        clr_in();
        wbs = 0;
        for (int k = 0; k < 40; k++) begin
            wbs += int'(bus.wb_valid);
            next_cyc();
        end
        chk("mid_no_wb", wbs, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/long_op_scoreboard.md
# long_op_scoreboard

Issue-stage hazard controller and sequencer for the shared iterative divide unit. It sits between the decoder and the register files, and tracks pending writes for a single in-flight long-latency op (DIV/DIVU/REM/REMU and FP divide) in separate integer and FP pending vectors. It stalls issue on RAW, WAW, structural and write-port hazards. It also drives the divider's start/step controls and the result write-back strobe.

## Interface
- REG_ADDR_WIDTH, 5, register index width
- NUM_REGS, 32, registers per file
- DIV_LATENCY, 32, divider iterations (>= 1)
- CNT_WIDTH, 6, counter width (must hold DIV_LATENCY-1)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- issue_valid  in  1  decoded instruction present in decode stage
- issue_long  in  1  instruction uses the divide unit
- rwe  in  1  instruction writes rd (decoder RWE)
- rd, rs1, rs2  in  REG_ADDR_WIDTH  register indices
- uses_rs1, uses_rs2  in  1  operand actually read
- f_rd, f_d1, f_d2  in  1  1 = FP file for rd/rs1/rs2, 0 = integer file
- issue_ready  out  1  combinational; instruction may issue this cycle
- stall  out  1  issue_valid & ~issue_ready
- div_start  out  1  one-cycle pulse; latch operands into divider
- div_step  out  1  divider iteration enable
- wb_valid  out  1  divider result written this cycle
- wb_rd  out  REG_ADDR_WIDTH  write-back index
- wb_f  out  1  write-back targets FP file
- busy  out  1  state != IDLE

## Operation
- Fire = issue_valid & issue_ready.
- State: int_pend[NUM_REGS], fp_pend[NUM_REGS], lat_rd, lat_f, lat_we, cnt, FSM {IDLE, RUN, WB}.
- Hazards; any of these forces issue_ready=0:
  - RAW1: uses_rs1 & pend[f_d1][rs1].
  - RAW2: uses_rs2 & pend[f_d2][rs2].
  - WAW: rwe & pend[f_rd][rd].
  - Structural: issue_long & state != IDLE.
  - Port: rwe & state == WB (single register-file write port; divider wins).
- Integer x0 is never marked pending. FP f0 is an ordinary register.
- IDLE: on fire & issue_long:
  - div_start=1 (same cycle, combinational).
  - Latch rd, f_rd, and we = rwe & ~(~f_rd & rd==0).
  - If we=1, set pend[f_rd][rd] at the edge.
  - cnt <= DIV_LATENCY-1; go to RUN.
- Short ops issue without touching the scoreboard.
- RUN: div_step=1. If cnt==0, go to WB; else cnt <= cnt-1.
- WB:
  - wb_valid = lat_we.
  - wb_rd = lat_rd, wb_f = lat_f.
  - Clear the pending bit at the edge; go to IDLE.
  - The pending bit is still set during WB, so dependents wait one more cycle (no bypass).
- A long op with lat_we=0 still runs the full sequence, but no wb_valid is asserted.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; both pend vectors, cnt and latches are cleared.
  - Any in-flight op is abandoned; no later wb_valid.
  - While rst_n=0, issue_ready=0, and div_start, div_step and wb_valid are 0.

## Timing
- Long op fires at cycle T: div_start at T, div_step at T+1..T+DIV_LATENCY, WB at T+DIV_LATENCY+1.
- First dependent (RAW/WAW) or next long op issues at T+DIV_LATENCY+2.
- Total occupancy is DIV_LATENCY+2 cycles per long op.
- Reset values:
  - issue_ready=0, stall=0.
  - div_start=0, div_step=0, wb_valid=0.
  - wb_rd=0, wb_f=0, busy=0.
- div_start, issue_ready and stall are combinational from inputs and state. All other outputs decode registered state only.
- A short op whose sources and destination are independent of the pending register issues in any cycle except when it has rwe=1 during WB.

## Test plan
- Reset:
  - Hold rst_n=0 for 2 cycles with issue_valid=1 and ADD x1,x2,x3 -> issue_ready=0 and all outputs 0.
  - Cycle after release -> issue_ready=1.
- Long-op sequence and RAW stall (DIV_LATENCY=32):
  - DIV x5 fires at T -> div_start at T, div_step at T+1..T+32, wb_valid=1/wb_rd=5/wb_f=0 at T+33.
  - ADD x6,x5,x1 presented from T+1 -> stall=1 through T+33, issues at T+34.
- Register-file separation:
  - DIV x5 in flight; FADD.S f6,f5,f1 (f_d1=1, rs1=5) -> issues without stall.
  - Op with rd=5, f_rd=1 -> issues.
  - Op with rd=5, f_rd=0, rwe=1 -> stalls (WAW).
- Structural and port hazards:
  - Back-to-back DIV at T, T+1 -> second stalls, issues at T+34.
  - At T+33 an unrelated ADD x9 (rwe=1) stalls one cycle and issues at T+34; a store (rwe=0) at T+33 issues immediately.
- x0 and no-write:
  - DIV x0 -> full sequence with div_step for 32 cycles, wb_valid never 1.
  - ADD x7,x0,x0 during the sequence -> no stall.
- Reset mid-operation:
  - DIV x5 at T; rst_n=0 at T+10 for one cycle -> busy=0 after the edge, no wb_valid ever.
  - ADD x6,x5,x1 issues the first cycle after release.
